// File: rtl/song_seq_ctrl_pkg.sv
// Shared types and defaults for the song sequencer: FSM state encoding,
// default field widths and the rom_data field layout.
package song_pkg;

  localparam int ADDR_W_DEF   = 5;
  localparam int PERIOD_W_DEF = 8;
  localparam int DUR_W_DEF    = 8;

  // rom_data = {period, duration}; duration occupies the LSBs, period sits directly above it
  localparam int DUR_LSB = 0;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    LOAD    = 3'd2,
    PLAY    = 3'd3,
    ADVANCE = 3'd4,
    FINISH  = 3'd5
  } state_t;

endpackage

// File: rtl/song_seq_ctrl_if.sv
// Song ROM read port and note-player control bundle between the sequencer
// (master) and the ROM / note player (slave).
interface song_seq_ctrl_if
  import song_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DUR_W    = DUR_W_DEF
);

  logic [ADDR_W-1:0]         rom_addr;
  logic [PERIOD_W+DUR_W-1:0] rom_data;
  logic [PERIOD_W-1:0]       player_period;
  logic                      player_load;
  logic                      player_en;

  modport master (
    output rom_addr, player_period, player_load, player_en,
    input  rom_data
  );

  modport slave (
    input  rom_addr, player_period, player_load, player_en,
    output rom_data
  );

endinterface

// File: rtl/song_seq_ctrl_dur_counter.sv
// Note duration down-counter: loaded with the note length, decremented on
// each qualified tick, flags when the next tick is the final one.
module song_dur_counter
  import song_pkg::*;
#(
  parameter int DUR_W = DUR_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DUR_W-1:0] load_val,
  input  logic             dec,
  output logic             last
);

  logic [DUR_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - DUR_W'(1);
    end
  end

  assign last = (cnt == DUR_W'(1));

endmodule

// File: rtl/song_seq_ctrl.sv
// Song sequencer: walks the song ROM, loads each note into the note player
// and holds it for its duration in ticks. Define SONG_SEQ_LOOP_EN to loop forever.
module song_seq_ctrl
  import song_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int DUR_W    = DUR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [ADDR_W:0]   song_len,
  input  logic              tick,
  song_seq_ctrl_if.master   bus,
  output logic              busy,
  output logic              done,
  output logic [2:0]        state
);

  state_t              cur_state, nxt_state;
  logic [ADDR_W-1:0]   index, index_nxt;
  logic [PERIOD_W-1:0] period_q, period_nxt;
  logic                en_q, en_nxt;
  logic                load_now, done_now;
  logic                last_tick, at_last_note;
  logic [PERIOD_W-1:0] rom_period;
  logic [DUR_W-1:0]    rom_dur;

  assign rom_dur      = bus.rom_data[DUR_LSB +: DUR_W];
  assign rom_period   = bus.rom_data[DUR_LSB + DUR_W +: PERIOD_W];
  assign at_last_note = (({1'b0, index} + (ADDR_W+1)'(1)) == song_len);

  song_dur_counter #(.DUR_W(DUR_W)) u_dur (
    .clk      (clk),
    .rst      (rst),
    .load     (load_now),
    .load_val (rom_dur),
    .dec      (tick && (cur_state == PLAY)),
    .last     (last_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur_state <= IDLE;
      index     <= '0;
      period_q  <= '0;
      en_q      <= 1'b0;
    end else begin
      cur_state <= nxt_state;
      index     <= index_nxt;
      period_q  <= period_nxt;
      en_q      <= en_nxt;
    end
  end

  // stop overrides every transition, including a start seen in the same cycle
  always_comb begin
    nxt_state  = cur_state;
    index_nxt  = index;
    period_nxt = period_q;
    en_nxt     = en_q;
    load_now   = 1'b0;
    done_now   = 1'b0;
    case (cur_state)
      IDLE: begin
        if (start && (song_len != '0)) nxt_state = FETCH;
      end
      FETCH: nxt_state = LOAD;
      LOAD: begin
        if (rom_dur != '0) begin
          load_now   = 1'b1;
          period_nxt = rom_period;
          en_nxt     = (rom_period != '0);
          nxt_state  = PLAY;
        end else begin
          nxt_state  = ADVANCE;
        end
      end
      PLAY: begin
        if (tick && last_tick) begin
          en_nxt    = 1'b0;
          nxt_state = ADVANCE;
        end
      end
      ADVANCE: begin
        if (at_last_note) begin
`ifdef SONG_SEQ_LOOP_EN
          index_nxt = '0;
          done_now  = 1'b1;
          nxt_state = FETCH;
`else
          nxt_state = FINISH;
`endif
        end else begin
          index_nxt = index + ADDR_W'(1);
          nxt_state = FETCH;
        end
      end
      FINISH: begin
        done_now  = 1'b1;
        index_nxt = '0;
        nxt_state = IDLE;
      end
      default: nxt_state = IDLE;
    endcase
    if (stop) begin
      nxt_state  = IDLE;
      index_nxt  = '0;
      period_nxt = period_q;
      en_nxt     = 1'b0;
      load_now   = 1'b0;
      done_now   = 1'b0;
    end
  end

  // the load pulse must carry the new period, so bypass the register while loading
  assign bus.player_period = load_now ? rom_period : period_q;
  assign bus.player_load   = load_now;
  assign bus.player_en     = en_q;
  assign bus.rom_addr      = (cur_state == IDLE) ? '0 : index;
  assign busy              = (cur_state != IDLE);
  assign done              = done_now;
  assign state             = cur_state;

endmodule

// File: tb/tb_song_seq_ctrl.sv
// Directed self-checking bench for song_seq_ctrl: ROM model, 1-in-4 tick
// generator and a negedge monitor that tallies loads, ticks, fetches and done.
module tb_song_seq_ctrl;
  import song_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int PERIOD_W = 8;
  localparam int DUR_W    = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              stop;
  logic [ADDR_W:0]   song_len;
  logic              tick = 1'b0;
  logic              busy;
  logic              done;
  logic [2:0]        state;
  logic              tick_on;
  int                tick_div = 0;
  logic [15:0]       rom [32];

  int total = 0;
  int bad   = 0;

  int epoch = 0;
  int seen_epoch = 0;
  int load_cnt, done_cnt, fetch_cnt, en_cycles;
  int load_period [32];
  int en_ticks    [32];
  int play_ticks  [32];
  int fetch_addr  [64];

  song_seq_ctrl_if #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W)) bus ();

  song_seq_ctrl #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .song_len (song_len),
    .tick     (tick),
    .bus      (bus),
    .busy     (busy),
    .done     (done),
    .state    (state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  always @(posedge clk) begin
    #1;
    if (tick_on) begin
      tick_div = (tick_div + 1) % 4;
      tick     = (tick_div == 0);
    end else begin
      tick_div = 0;
      tick     = 1'b0;
    end
  end

  // per-note tallies are indexed by how many load pulses have been seen so far
  always @(negedge clk) begin
    if (seen_epoch != epoch) begin
      seen_epoch = epoch;
      load_cnt = 0; done_cnt = 0; fetch_cnt = 0; en_cycles = 0;
      for (int i = 0; i < 32; i++) begin
        load_period[i] = -1; en_ticks[i] = 0; play_ticks[i] = 0;
      end
      for (int i = 0; i < 64; i++) fetch_addr[i] = -1;
    end
    if (bus.player_load) begin
      if (load_cnt < 32) load_period[load_cnt] = int'(bus.player_period);
      load_cnt++;
    end
    if (tick && load_cnt > 0 && load_cnt <= 32) begin
      if (bus.player_en) en_ticks[load_cnt-1]++;
      if (state_t'(state) == PLAY) play_ticks[load_cnt-1]++;
    end
    if (bus.player_en) en_cycles++;
    if (done) done_cnt++;
    if (state_t'(state) == FETCH) begin
      if (fetch_cnt < 64) fetch_addr[fetch_cnt] = int'(bus.rom_addr);
      fetch_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic clearMonitor();
    epoch++;
  endtask

  task automatic applyStimulus(input logic s, input logic p);
    @(posedge clk); #1;
    start = s;
    stop  = p;
    @(posedge clk); #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic waitIdle(input string tag, input int budget);
    for (int n = 0; n < budget && busy; n++) begin @(posedge clk); #1; end
    checkOutput(tag, int'(busy), 0);
  endtask

  task automatic waitPlay(input string tag, input int note, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (load_cnt == note + 1 && state_t'(state) == PLAY) break;
      @(posedge clk); #1;
    end
    checkOutput(tag, int'(load_cnt == note + 1 && state_t'(state) == PLAY), 1);
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; song_len = '0; tick_on = 1'b0;
    for (int i = 0; i < 32; i++) rom[i] = 16'h0000;
    clearMonitor();
    waitCycles(2);
    checkOutput("rst_state", int'(state), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_en", int'(bus.player_en), 0);
    checkOutput("rst_load", int'(bus.player_load), 0);
    checkOutput("rst_period", int'(bus.player_period), 0);
    checkOutput("rst_addr", int'(bus.rom_addr), 0);
    rst = 1'b1;
    tick_on = 1'b1;
    waitCycles(2);

`ifdef SONG_SEQ_LOOP_EN
    rom[0] = {8'd20, 8'd1};
    song_len = 6'd1;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    for (int n = 0; n < 300 && done_cnt < 3; n++) begin @(posedge clk); #1; end
    checkOutput("loop_done3", done_cnt, 3);
    checkOutput("loop_busy", int'(busy), 1);
    checkOutput("loop_no_skip", int'(load_cnt >= 3), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("loop_stop_busy", int'(busy), 0);
    checkOutput("loop_stop_en", int'(bus.player_en), 0);
`else
    // two-note song
    rom[0] = {8'd20, 8'd3};
    rom[1] = {8'd35, 8'd2};
    song_len = 6'd2;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    checkOutput("a_busy", int'(busy), 1);
    waitIdle("a_end", 200);
    checkOutput("a_loads", load_cnt, 2);
    checkOutput("a_period0", load_period[0], 20);
    checkOutput("a_period1", load_period[1], 35);
    checkOutput("a_en_ticks0", en_ticks[0], 3);
    checkOutput("a_en_ticks1", en_ticks[1], 2);
    checkOutput("a_done", done_cnt, 1);
    checkOutput("a_hold_period", int'(bus.player_period), 35);
    checkOutput("a_en_off", int'(bus.player_en), 0);

    // rest note followed by a short note
    rom[0] = {8'd0, 8'd2};
    rom[1] = {8'd35, 8'd1};
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitPlay("r_reach1", 1, 200);
    checkOutput("r_en_silent", en_cycles, 0);
    checkOutput("r_period0", load_period[0], 0);
    checkOutput("r_play_ticks0", play_ticks[0], 2);
    waitIdle("r_end", 200);
    checkOutput("r_loads", load_cnt, 2);
    checkOutput("r_done", done_cnt, 1);

    // zero-duration note is skipped
    rom[0] = {8'd20, 8'd1};
    rom[1] = {8'd50, 8'd0};
    rom[2] = {8'd35, 8'd1};
    song_len = 6'd3;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitIdle("s_end", 200);
    checkOutput("s_loads", load_cnt, 2);
    checkOutput("s_period1", load_period[1], 35);
    checkOutput("s_fetches", fetch_cnt, 3);
    checkOutput("s_addr0", fetch_addr[0], 0);
    checkOutput("s_addr1", fetch_addr[1], 1);
    checkOutput("s_addr2", fetch_addr[2], 2);
    checkOutput("s_done", done_cnt, 1);

    // start while busy must not restart the walk
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitCycles(3);
    applyStimulus(1'b1, 1'b0);
    waitIdle("b_end", 200);
    checkOutput("b_fetches", fetch_cnt, 3);
    checkOutput("b_addr2", fetch_addr[2], 2);
    checkOutput("b_done", done_cnt, 1);

    // stop during the second note
    rom[0] = {8'd20, 8'd3};
    rom[1] = {8'd35, 8'd2};
    song_len = 6'd2;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitPlay("t_reach1", 1, 200);
    checkOutput("t_en_before", int'(bus.player_en), 1);
    applyStimulus(1'b0, 1'b1);
    checkOutput("t_state", int'(state), 0);
    checkOutput("t_en", int'(bus.player_en), 0);
    checkOutput("t_busy", int'(busy), 0);
    waitCycles(3);
    checkOutput("t_no_done", done_cnt, 0);
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitIdle("t_replay_end", 200);
    checkOutput("t_replay_addr0", fetch_addr[0], 0);
    checkOutput("t_replay_loads", load_cnt, 2);
    checkOutput("t_replay_done", done_cnt, 1);

    // empty song and start+stop together
    song_len = 6'd0;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitCycles(2);
    checkOutput("e_busy", int'(busy), 0);
    checkOutput("e_done", done_cnt, 0);
    song_len = 6'd2;
    applyStimulus(1'b1, 1'b1);
    checkOutput("ss_busy", int'(busy), 0);
    checkOutput("ss_fetch", fetch_cnt, 0);

    // full-length song uses every ROM entry
    for (int i = 0; i < 32; i++) rom[i] = {8'(i + 1), 8'd1};
    song_len = 6'd32;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitIdle("f_end", 2000);
    checkOutput("f_loads", load_cnt, 32);
    checkOutput("f_period31", load_period[31], 32);
    checkOutput("f_fetches", fetch_cnt, 32);
    checkOutput("f_addr31", fetch_addr[31], 31);
    checkOutput("f_done", done_cnt, 1);

    // asynchronous reset between edges mid-note
    rom[0] = {8'd20, 8'd3};
    rom[1] = {8'd35, 8'd2};
    song_len = 6'd2;
    clearMonitor();
    applyStimulus(1'b1, 1'b0);
    waitPlay("x_reach0", 0, 200);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("x_en", int'(bus.player_en), 0);
    checkOutput("x_busy", int'(busy), 0);
    checkOutput("x_state", int'(state), 0);
    checkOutput("x_period", int'(bus.player_period), 0);
    checkOutput("x_addr", int'(bus.rom_addr), 0);
    #1;
    rst = 1'b1;
    waitCycles(3);
    checkOutput("x_idle_after", int'(state), 0);
    checkOutput("x_en_after", int'(bus.player_en), 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/song_seq_ctrl.md
Name: song_seq_ctrl

Overview:
- Sequencer that plays a song from a synchronous song ROM through one note-player datapath.
- Per note: fetches a {period, duration} entry, loads the period into the note player, holds it for `duration` ticks, then advances.
- Sits between the top-level user controls (start/stop) and the note player's period-load and enable inputs.
- Shares the tick strobe (1 ms) with the rest of the music subsystem.

Parameters:
- ADDR_W, 5: song ROM address width; max song length 2^ADDR_W notes.
- PERIOD_W, 8: note half-period field width.
- DUR_W, 8: note duration field width, in ticks.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- start  in  1  one-cycle request to begin playback; ignored unless idle.
- stop  in  1  abort playback; wins over start.
- song_len  in  ADDR_W+1  number of notes in the song; 0 means empty.
- tick  in  1  one-cycle duration strobe.
- rom_addr  out  ADDR_W  song ROM read address.
- rom_data  in  PERIOD_W+DUR_W  {period, duration}; valid the cycle after rom_addr.
- player_period  out  PERIOD_W  period presented to the note player.
- player_load  out  1  one-cycle pulse; note player reloads its counter.
- player_en  out  1  note player output enable; 0 = silence.
- busy  out  1  high in any non-IDLE state.
- done  out  1  one-cycle pulse at natural song end.
- state  out  3  current FSM state, for debug.

Behaviour:
- Reset: asynchronous. All outputs 0, FSM in IDLE, note index 0, duration counter 0. Reset mid-song silences the player immediately.
- FSM states:
  - IDLE: rom_addr=0.
    - start && !stop && song_len!=0 -> FETCH.
    - start with song_len==0 -> stays IDLE, no done.
  - FETCH (1 cycle): rom_addr=index -> LOAD.
  - LOAD (1 cycle): rom_data is valid.
    - duration!=0: player_period<=period; player_load=1 this cycle; dur_cnt<=duration; player_en<=(period!=0) from next cycle; -> PLAY.
    - duration==0: note skipped; no load pulse; -> ADVANCE.
  - PLAY: on tick, dur_cnt decrements. tick && dur_cnt==1 -> ADVANCE; player_en<=0 that edge.
  - ADVANCE (1 cycle):
    - index==song_len-1 -> FINISH.
    - otherwise index<=index+1 -> FETCH.
  - FINISH: done=1 for one cycle; index<=0 -> IDLE.
- Period 0 is a rest: load still pulses, player_en stays 0, and duration is honoured.
- Note timing: an N-tick note plays from the cycle after LOAD until the edge at which the Nth tick is seen.
- Inter-note overhead is 3 cycles (ADVANCE, FETCH, LOAD).
- stop:
  - In any state, next edge -> IDLE; index<=0; player_en<=0; no done.
  - stop && start in the same cycle -> IDLE.
- start while busy is ignored.
- tick arriving in FETCH/LOAD/ADVANCE is ignored; the duration count begins in PLAY.
- A full-length song (song_len=2^ADDR_W) plays all entries. The index never wraps mid-song.
- player_period holds its last value after stop or FINISH; only player_en gates the sound.

Optional Feature:
- SONG_SEQ_LOOP_EN. When defined, ADVANCE at the last note returns to FETCH with index<=0, and done pulses for one cycle on each wrap.
- With the macro defined, playback ends only on stop or reset.
- When undefined, behaviour is exactly as above (FINISH -> IDLE).

Decomposition:
- Package song_pkg holds:
  - state enum: IDLE=0, FETCH=1, LOAD=2, PLAY=3, ADVANCE=4, FINISH=5;
  - field-slice localparams for rom_data (period in the MSBs, duration in the LSBs);
  - default widths.
- One natural sub-module: song_dur_counter (DUR_W down-counter with load, tick-gated decrement and a last-tick flag).

Test Plan:
- Reset then start with song_len=2, ROM[0]={8'd20,8'd3}, ROM[1]={8'd35,8'd2}, tick every 4 cycles:
  - player_load pulses carrying period 20, then 35;
  - player_en high for exactly 3 ticks, then 2 ticks;
  - done pulses once; busy then low.
- ROM[0]={8'd0,8'd2} (rest): player_load pulses, player_en stays 0 for 2 ticks, then the sequencer advances.
- ROM[1] duration 0 in a 3-note song: no player_load for note 1; rom_addr goes 0,1,2; done after note 2.
- stop asserted during PLAY of note 1:
  - next cycle IDLE, player_en=0, busy=0, no done;
  - a later start replays from rom_addr 0.
- start with song_len=0 -> stays IDLE, busy=0, done=0. start asserted while busy -> rom_addr sequence unchanged.
- rst driven 0 mid-PLAY (asynchronous, between edges): outputs clear immediately; after release, IDLE. Under SONG_SEQ_LOOP_EN, a 1-note song loops and done pulses on every wrap.
